alu_reservation_station: RTL and testbench

//  Reservation station feeding the ALU issue/execute stage. Buffers dispatched ALU ops, captures

---
 rtl/rs_pkg.sv | 28 ++
 rtl/rs_select.sv | 66 ++++++
 rtl/alu_reservation_station.sv | 138 +++++++++++++
 tb/tb_alu_reservation_station.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and widths for the ALU reservation station.
// Slot record, ROB tag width and command-word field positions.
package rs_pkg;
    localparam int ROBsize       = 32;
    localparam int ROBsizeLog    = $clog2(ROBsize + 1);
    localparam int CMD_W         = 10;
    localparam int DATA_W        = 64;
    localparam int ALU_CNTRL_LSB = 2;
    localparam int ALU_CNTRL_MSB = 4;

    typedef logic [ROBsizeLog-1:0] rob_tag_t;

    typedef struct packed {
        logic              valid;
        logic [CMD_W-1:0]  cmd;
        rob_tag_t          tag;
        logic              rdy1;
        rob_tag_t          src1;
        logic [DATA_W-1:0] val1;
        logic              rdy2;
        rob_tag_t          src2;
        logic [DATA_W-1:0] val2;
    } rsEntry_t;

    function automatic logic [ALU_CNTRL_MSB-ALU_CNTRL_LSB:0] alu_cntrl(input logic [CMD_W-1:0] cmd);
        return cmd[ALU_CNTRL_MSB:ALU_CNTRL_LSB];
    endfunction
endpackage

// File: rtl/rs_select.sv
// Issue selection: eligible vector -> one-hot grant.
// RS_AGE_PRIORITY_EN selects oldest-first via an age matrix; otherwise lowest index wins.
module rs_select #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [N-1:0] eligible_i,
    input  logic [N-1:0] alloc_i,
    input  logic         flush_i,
    output logic [N-1:0] grant_o,
    output logic         any_o
);
    assign any_o = |eligible_i;

`ifdef RS_AGE_PRIORITY_EN
    // older_q[i][j] set means slot i was dispatched before slot j
    logic [N-1:0] older_q [N];
    logic         blocked;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < N; i++) older_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < N; i++) older_q[i] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (alloc_i[k]) begin
                    older_q[k] <= '0;
                    for (int j = 0; j < N; j++) begin
                        if (j != k) older_q[j][k] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_o = '0;
        blocked = 1'b0;
        for (int i = 0; i < N; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j != i && eligible_i[j] && older_q[j][i]) blocked = 1'b1;
            end
            grant_o[i] = eligible_i[i] && !blocked;
        end
    end
`else
    logic taken;
    logic unused_age;

    assign unused_age = ^{clk_i, reset_i, alloc_i, flush_i};

    always_comb begin
        grant_o = '0;
        taken   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (eligible_i[i] && !taken) begin
                grant_o[i] = 1'b1;
                taken      = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: slot array with CDB wakeup and one-op-per-cycle issue.
// Optional oldest-first issue when RS_AGE_PRIORITY_EN is defined.
module alu_reservation_station
    import rs_pkg::*;
#(
    parameter int RSentries = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  dispatchValid_i,
    output logic                  dispatchReady_o,
    input  logic [CMD_W-1:0]      dispatchCommands_i,
    input  logic [ROBsizeLog-1:0] dispatchTag_i,
    input  logic [DATA_W-1:0]     dispatchVal1_i,
    input  logic [DATA_W-1:0]     dispatchVal2_i,
    input  logic                  dispatchRdy1_i,
    input  logic                  dispatchRdy2_i,
    input  logic [ROBsizeLog-1:0] dispatchSrc1_i,
    input  logic [ROBsizeLog-1:0] dispatchSrc2_i,
    input  logic                  cdbValid_i,
    input  logic [ROBsizeLog-1:0] cdbTag_i,
    input  logic [DATA_W-1:0]     cdbVal_i,
    output logic [DATA_W-1:0]     reservationStationVal1_o,
    output logic [DATA_W-1:0]     reservationStationVal2_o,
    output logic [CMD_W-1:0]      reservationStationCommands_o,
    output logic [ROBsizeLog-1:0] reservationStationTag_o,
    output logic                  readyRS_o,
    input  logic                  stallRS_i
);
    rsEntry_t slot_q [RSentries];
    rsEntry_t slot_d [RSentries];
    rsEntry_t new_entry;
    rsEntry_t issue_entry;

    logic [RSentries-1:0] free_vec;
    logic [RSentries-1:0] eligible_vec;
    logic [RSentries-1:0] alloc_vec;
    logic [RSentries-1:0] alloc_fire;
    logic [RSentries-1:0] grant_vec;
    logic                 alloc_taken;
    logic                 any_eligible;
    logic                 dispatch_fire;
    logic                 issue_fire;

    always_comb begin
        free_vec     = '0;
        eligible_vec = '0;
        alloc_vec    = '0;
        alloc_taken  = 1'b0;
        for (int i = 0; i < RSentries; i++) begin
            free_vec[i]     = !slot_q[i].valid;
            eligible_vec[i] = slot_q[i].valid && slot_q[i].rdy1 && slot_q[i].rdy2;
            if (!slot_q[i].valid && !alloc_taken) begin
                alloc_vec[i] = 1'b1;
                alloc_taken  = 1'b1;
            end
        end
    end

    assign dispatchReady_o = |free_vec;
    assign dispatch_fire   = dispatchValid_i && dispatchReady_o && !flush_i;
    assign alloc_fire      = dispatch_fire ? alloc_vec : '0;
    assign issue_fire      = any_eligible && !stallRS_i && !flush_i;

    rs_select #(.N(RSentries)) u_select (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .eligible_i (eligible_vec),
        .alloc_i    (alloc_fire),
        .flush_i    (flush_i),
        .grant_o    (grant_vec),
        .any_o      (any_eligible)
    );

    // An operand produced on the CDB in the dispatch cycle is captured here, not lost.
    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.cmd   = dispatchCommands_i;
        new_entry.tag   = dispatchTag_i;
        new_entry.src1  = dispatchSrc1_i;
        new_entry.src2  = dispatchSrc2_i;
        new_entry.rdy1  = dispatchRdy1_i;
        new_entry.val1  = dispatchVal1_i;
        new_entry.rdy2  = dispatchRdy2_i;
        new_entry.val2  = dispatchVal2_i;
        if (!dispatchRdy1_i && cdbValid_i && cdbTag_i == dispatchSrc1_i) begin
            new_entry.rdy1 = 1'b1;
            new_entry.val1 = cdbVal_i;
        end
        if (!dispatchRdy2_i && cdbValid_i && cdbTag_i == dispatchSrc2_i) begin
            new_entry.rdy2 = 1'b1;
            new_entry.val2 = cdbVal_i;
        end
    end

    always_comb begin
        for (int i = 0; i < RSentries; i++) begin
            slot_d[i] = slot_q[i];
            if (slot_q[i].valid && cdbValid_i) begin
                if (!slot_q[i].rdy1 && slot_q[i].src1 == cdbTag_i) begin
                    slot_d[i].rdy1 = 1'b1;
                    slot_d[i].val1 = cdbVal_i;
                end
                if (!slot_q[i].rdy2 && slot_q[i].src2 == cdbTag_i) begin
                    slot_d[i].rdy2 = 1'b1;
                    slot_d[i].val2 = cdbVal_i;
                end
            end
            if (issue_fire && grant_vec[i]) slot_d[i].valid = 1'b0;
            if (alloc_fire[i])              slot_d[i] = new_entry;
            if (flush_i)                    slot_d[i].valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < RSentries; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < RSentries; i++) slot_q[i] <= slot_d[i];
        end
    end

    // With no grant the outputs fall back to slot 0.
    always_comb begin
        issue_entry = slot_q[0];
        for (int i = 0; i < RSentries; i++) begin
            if (grant_vec[i]) issue_entry = slot_q[i];
        end
    end

    assign readyRS_o                    = any_eligible;
    assign reservationStationVal1_o     = issue_entry.val1;
    assign reservationStationVal2_o     = issue_entry.val2;
    assign reservationStationCommands_o = issue_entry.cmd;
    assign reservationStationTag_o      = issue_entry.tag;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station.
// Expectations for issue order follow RS_AGE_PRIORITY_EN when it is defined.
module tb_alu_reservation_station;
    import rs_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  reset_i;
    logic                  flush_i;
    logic                  dispatchValid_i;
    logic                  dispatchReady_o;
    logic [CMD_W-1:0]      dispatchCommands_i;
    logic [ROBsizeLog-1:0] dispatchTag_i;
    logic [DATA_W-1:0]     dispatchVal1_i;
    logic [DATA_W-1:0]     dispatchVal2_i;
    logic                  dispatchRdy1_i;
    logic                  dispatchRdy2_i;
    logic [ROBsizeLog-1:0] dispatchSrc1_i;
    logic [ROBsizeLog-1:0] dispatchSrc2_i;
    logic                  cdbValid_i;
    logic [ROBsizeLog-1:0] cdbTag_i;
    logic [DATA_W-1:0]     cdbVal_i;
    logic [DATA_W-1:0]     reservationStationVal1_o;
    logic [DATA_W-1:0]     reservationStationVal2_o;
    logic [CMD_W-1:0]      reservationStationCommands_o;
    logic [ROBsizeLog-1:0] reservationStationTag_o;
    logic                  readyRS_o;
    logic                  stallRS_i;

    int tests = 0;
    int fails = 0;

    alu_reservation_station #(.RSentries(4)) dut (
        .clk_i                        (clk_i),
        .reset_i                      (reset_i),
        .flush_i                      (flush_i),
        .dispatchValid_i              (dispatchValid_i),
        .dispatchReady_o              (dispatchReady_o),
        .dispatchCommands_i           (dispatchCommands_i),
        .dispatchTag_i                (dispatchTag_i),
        .dispatchVal1_i               (dispatchVal1_i),
        .dispatchVal2_i               (dispatchVal2_i),
        .dispatchRdy1_i               (dispatchRdy1_i),
        .dispatchRdy2_i               (dispatchRdy2_i),
        .dispatchSrc1_i               (dispatchSrc1_i),
        .dispatchSrc2_i               (dispatchSrc2_i),
        .cdbValid_i                   (cdbValid_i),
        .cdbTag_i                     (cdbTag_i),
        .cdbVal_i                     (cdbVal_i),
        .reservationStationVal1_o     (reservationStationVal1_o),
        .reservationStationVal2_o     (reservationStationVal2_o),
        .reservationStationCommands_o (reservationStationCommands_o),
        .reservationStationTag_o      (reservationStationTag_o),
        .readyRS_o                    (readyRS_o),
        .stallRS_i                    (stallRS_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic dispatch(input logic [5:0] tag, input logic [63:0] v1, input logic [63:0] v2,
                            input logic r1, input logic r2, input logic [5:0] s1, input logic [5:0] s2);
        dispatchValid_i    = 1'b1;
        dispatchCommands_i = 10'h01C;
        dispatchTag_i      = tag;
        dispatchVal1_i     = v1;
        dispatchVal2_i     = v2;
        dispatchRdy1_i     = r1;
        dispatchRdy2_i     = r2;
        dispatchSrc1_i     = s1;
        dispatchSrc2_i     = s2;
    endtask

    task automatic idle;
        dispatchValid_i = 1'b0;
        cdbValid_i      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] first_tag;
        logic [5:0] second_tag;
`ifdef RS_AGE_PRIORITY_EN
        first_tag  = 6'd1;
        second_tag = 6'd2;
`else
        first_tag  = 6'd2;
        second_tag = 6'd1;
`endif
        reset_i = 1'b0; flush_i = 1'b0; stallRS_i = 1'b0;
        dispatchValid_i = 1'b0; dispatchCommands_i = '0; dispatchTag_i = '0;
        dispatchVal1_i = '0; dispatchVal2_i = '0; dispatchRdy1_i = 1'b0; dispatchRdy2_i = 1'b0;
        dispatchSrc1_i = '0; dispatchSrc2_i = '0;
        cdbValid_i = 1'b0; cdbTag_i = '0; cdbVal_i = '0;

        @(negedge clk_i);
        check("reset_ready",   readyRS_o, 0);
        check("reset_dready",  dispatchReady_o, 1);
        check("reset_val1",    reservationStationVal1_o, 0);
        check("reset_tag",     reservationStationTag_o, 0);
        reset_i = 1'b1;

        // both operands ready: issue next cycle
        dispatch(6'd3, 64'd15, 64'd3, 1'b1, 1'b1, 6'd0, 6'd0);
        tick; idle;
        check("t1_ready", readyRS_o, 1);
        check("t1_val1",  reservationStationVal1_o, 15);
        check("t1_val2",  reservationStationVal2_o, 3);
        check("t1_tag",   reservationStationTag_o, 3);
        check("t1_cmd",   reservationStationCommands_o, 10'h01C);
        tick;
        check("t1_drained", readyRS_o, 0);

        // wakeup via CDB two cycles after dispatch
        dispatch(6'd5, 64'd0, 64'd4, 1'b0, 1'b1, 6'd2, 6'd0);
        tick; idle;
        check("t2_wait", readyRS_o, 0);
        tick;
        cdbValid_i = 1'b1; cdbTag_i = 6'd2; cdbVal_i = 64'd7;
        check("t2_bcast_cycle", readyRS_o, 0);
        tick; idle;
        check("t2_ready", readyRS_o, 1);
        check("t2_val1",  reservationStationVal1_o, 7);
        check("t2_val2",  reservationStationVal2_o, 4);
        check("t2_tag",   reservationStationTag_o, 5);
        tick;
        check("t2_drained", readyRS_o, 0);

        // same-cycle capture at dispatch
        dispatch(6'd6, 64'd1, 64'd0, 1'b1, 1'b0, 6'd0, 6'd9);
        cdbValid_i = 1'b1; cdbTag_i = 6'd9; cdbVal_i = 64'hAA;
        tick; idle;
        check("t3_ready", readyRS_o, 1);
        check("t3_val2",  reservationStationVal2_o, 64'hAA);
        check("t3_tag",   reservationStationTag_o, 6);
        tick;
        check("t3_drained", readyRS_o, 0);

        // fill under stall, then drain
        stallRS_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dispatch(6'(10 + i), 64'(256 + i), 64'd0, 1'b1, 1'b1, 6'd0, 6'd0);
            tick;
        end
        check("t4_full_dready", dispatchReady_o, 0);
        check("t4_hold_tag",    reservationStationTag_o, 10);
        check("t4_hold_val1",   reservationStationVal1_o, 256);
        dispatch(6'd14, 64'd0, 64'd0, 1'b1, 1'b1, 6'd0, 6'd0);
        tick; idle;
        check("t4_full_ignored_tag", reservationStationTag_o, 10);
        check("t4_still_full",       dispatchReady_o, 0);
        stallRS_i = 1'b0;
        check("t4_release_dready",   dispatchReady_o, 0);
        tick;
        check("t4_dready_after_xfer", dispatchReady_o, 1);
        check("t4_tag11", reservationStationTag_o, 11);
        tick;
        check("t4_tag12", reservationStationTag_o, 12);
        tick;
        check("t4_tag13", reservationStationTag_o, 13);
        tick;
        check("t4_drained", readyRS_o, 0);

        // priority: tag 2 sits in a lower slot than older tag 1
        stallRS_i = 1'b1;
        dispatch(6'd20, 64'h20, 64'd0, 1'b1, 1'b1, 6'd0, 6'd0);
        tick;
        dispatch(6'd1, 64'h01, 64'd0, 1'b1, 1'b1, 6'd0, 6'd0);
        tick; idle;
        stallRS_i = 1'b0;
        check("t5_tag20", reservationStationTag_o, 20);
        tick;
        stallRS_i = 1'b1;
        dispatch(6'd2, 64'h02, 64'd0, 1'b1, 1'b1, 6'd0, 6'd0);
        tick; idle;
        check("t5_first",  reservationStationTag_o, first_tag);
        stallRS_i = 1'b0;
        tick;
        check("t5_second", reservationStationTag_o, second_tag);
        tick;
        check("t5_drained", readyRS_o, 0);

        // flush with three entries, dispatch in flush cycle dropped
        stallRS_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dispatch(6'(21 + i), 64'd0, 64'd0, 1'b1, 1'b1, 6'd0, 6'd0);
            tick;
        end
        check("t6_pre_tag", reservationStationTag_o, 21);
        stallRS_i = 1'b0; flush_i = 1'b1;
        dispatch(6'd24, 64'd0, 64'd0, 1'b1, 1'b1, 6'd0, 6'd0);
        tick; idle;
        flush_i = 1'b0;
        check("t6_flush_ready",  readyRS_o, 0);
        check("t6_flush_dready", dispatchReady_o, 1);

        // async reset while a wakeup is pending
        dispatch(6'd25, 64'd0, 64'h55, 1'b0, 1'b1, 6'd3, 6'd0);
        tick; idle;
        check("t6_pre_reset_val2", reservationStationVal2_o, 64'h55);
        cdbValid_i = 1'b1; cdbTag_i = 6'd3; cdbVal_i = 64'h99;
        #2 reset_i = 1'b0;
        #1;
        check("t6_reset_ready", readyRS_o, 0);
        check("t6_reset_val2",  reservationStationVal2_o, 0);
        check("t6_reset_tag",   reservationStationTag_o, 0);
        tick; idle;
        check("t6_reset_held_ready", readyRS_o, 0);
        check("t6_reset_dready",     dispatchReady_o, 1);
        reset_i = 1'b1;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
